gpio_in_capture: RTL and testbench

- Input-side GPIO event capture for the SoC; consumes the external `gpio_in` bus.
- Synchronises `gpio_in` and detects per-bit rising/falling edges under enable masks.
- Queues each event as {sampled value, timestamp} in a small first-word-fall-through (FWFT) FIFO for the core to read.
- Provides a level interrupt and a sticky overflow flag.

---
 rtl/gpio_in_capture.sv | 139 +++++++++++++
 tb/tb_gpio_in_capture.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_capture.sv
// rtl/gpio_in_capture.sv - GPIO input edge capture with timestamped FWFT event FIFO
module gpio_in_capture #(
  parameter int DW      = 16,
  parameter int TSW     = 16,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      gpio_in,
  input  logic [DW-1:0]      rise_en,
  input  logic [DW-1:0]      fall_en,
  input  logic               rd_en,
  output logic [DW-1:0]      rd_val,
  output logic [TSW-1:0]     rd_ts,
  output logic               evt_valid,
  output logic               irq,
  output logic [FIFO_AW:0]   evt_cnt,
  output logic               ovf,
  input  logic               ovf_clr
);

  localparam int                 DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [TSW-1:0]     TS_ONE     = TSW'(1);
  // Detection waits until both synchroniser stages and prev hold real pin
  // samples, so a static pin level at reset release never looks like an edge.
  localparam logic [1:0]         PRIME_DONE = 2'd3;

  logic [DW-1:0]      sync1_q, sync2_q, prev_q;
  logic [TSW-1:0]     ts_q, ts_d;
  logic [1:0]         prime_q, prime_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [DW-1:0]      val_mem_q [DEPTH];
  logic [TSW-1:0]     ts_mem_q  [DEPTH];

  logic [DW-1:0]      edge_hit;
  logic               push, pop, full, wr, drop;

  // Edge detection, FIFO push/pop arbitration and next-state computation
  always_comb begin
    edge_hit = '0;
    push     = 1'b0;
    pop      = 1'b0;
    full     = 1'b0;
    wr       = 1'b0;
    drop     = 1'b0;
    ts_d     = ts_q + TS_ONE;
    prime_d  = prime_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (prime_q != PRIME_DONE) begin
      prime_d = prime_q + 2'd1;
    end

    if (prime_q == PRIME_DONE) begin
      edge_hit = (sync2_q & ~prev_q & rise_en) | (~sync2_q & prev_q & fall_en);
    end
    push = |edge_hit;

    // A pop on an empty FIFO is ignored, so an empty-FIFO push+pop just pushes.
    pop  = rd_en & (cnt_q != '0);
    full = (cnt_q == CNT_FULL);
    wr   = push & (~full | pop);
    drop = push & full & ~pop;

    if (wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    // A dropped push in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Synchroniser, history, timestamp, priming and FIFO control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      ts_q     <= '0;
      prime_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      ts_q     <= ts_d;
      prime_q  <= prime_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Event storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_mem_q[i] <= '0;
        ts_mem_q[i]  <= '0;
      end
    end else if (wr) begin
      val_mem_q[wr_ptr_q] <= sync2_q;
      ts_mem_q[wr_ptr_q]  <= ts_q;
    end
  end

  assign rd_val    = val_mem_q[rd_ptr_q];
  assign rd_ts     = ts_mem_q[rd_ptr_q];
  assign evt_valid = (cnt_q != '0);
  assign irq       = evt_valid;
  assign evt_cnt   = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
// tb/tb_gpio_in_capture.sv - self-checking bench for gpio_in_capture
module tb_gpio_in_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpio_in, rise_en, fall_en;
  logic        rd_en, ovf_clr;

  logic [15:0] rd_val, rd_ts;
  logic        evt_valid, irq, ovf;
  logic [2:0]  evt_cnt;

  logic [15:0] rd_val4;
  logic [3:0]  rd_ts4;
  logic        evt_valid4, irq4, ovf4;
  logic [2:0]  evt_cnt4;

  always #5 clk = ~clk;

  gpio_in_capture dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .rise_en(rise_en), .fall_en(fall_en),
    .rd_en(rd_en), .rd_val(rd_val), .rd_ts(rd_ts), .evt_valid(evt_valid), .irq(irq),
    .evt_cnt(evt_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  gpio_in_capture #(.TSW(4)) dut4 (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .rise_en(rise_en), .fall_en(fall_en),
    .rd_en(rd_en), .rd_val(rd_val4), .rd_ts(rd_ts4), .evt_valid(evt_valid4), .irq(irq4),
    .evt_cnt(evt_cnt4), .ovf(ovf4), .ovf_clr(ovf_clr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pin history per cycle since reset, event queue, overflow flag
  typedef struct packed {
    logic [15:0] v;
    logic [31:0] k;
  } ent_t;

  int          c = 0;
  logic [15:0] hist [4096];
  ent_t        q [$];
  logic        m_ovf = 1'b0;
  logic [15:0] exp_drain [4] = '{16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    ent_t h;
    chk("m_cnt", 32'(evt_cnt), q.size());
    chk("m_valid", 32'(evt_valid), 32'(q.size() > 0));
    chk("m_irq", 32'(irq), 32'(q.size() > 0));
    chk("m_ovf", 32'(ovf), 32'(m_ovf));
    chk("m_cnt4", 32'(evt_cnt4), q.size());
    chk("m_ovf4", 32'(ovf4), 32'(m_ovf));
    if (q.size() > 0) begin
      h = q[0];
      chk("m_rd_val", 32'(rd_val), 32'(h.v));
      chk("m_rd_ts", 32'(rd_ts), 32'(h.k[15:0]));
      chk("m_rd_val4", 32'(rd_val4), 32'(h.v));
      chk("m_rd_ts4", 32'(rd_ts4), 32'(h.k[3:0]));
    end
  endtask

  // One clock: the model evaluates the cycle that this edge closes, then checks.
  // An event seen in cycle k uses the pins driven in cycles k-2 (now) and k-3 (before).
  task automatic tick();
    logic [15:0] s, p, e;
    bit          push, pop, drop;
    ent_t        ent;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      c = 0;
    end else begin
      hist[c % 4096] = gpio_in;
      push = 1'b0;
      s = '0;
      if (c >= 3) begin
        s = hist[(c - 2) % 4096];
        p = hist[(c - 3) % 4096];
        e = (s & ~p & rise_en) | (~s & p & fall_en);
        push = (e != 0);
      end
      pop = rd_en && (q.size() > 0);
      if (pop) void'(q.pop_front());
      drop = push && (q.size() == 4);
      if (push && !drop) begin
        ent.v = s;
        ent.k = c;
        q.push_back(ent);
      end
      m_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      c++;
    end
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; gpio_in = 16'hFA1C; rise_en = 16'hFFFF; fall_en = 16'hFFFF;
    rd_en = 1'b0; ovf_clr = 1'b0;

    // Reset values and a static nonzero pin level at release
    ticks(3);
    chk("rst_rd_val", 32'(rd_val), 0);
    chk("rst_rd_ts", 32'(rd_ts), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_cnt", 32'(evt_cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b1;
    repeat (10) begin
      tick();
      chk("prime_cnt", 32'(evt_cnt), 0);
      chk("prime_ovf", 32'(ovf), 0);
    end

    // Single edge at ts=5, visible three cycles later with timestamp 7
    rst = 1'b0; tick(); rst = 1'b1;
    ticks(5);
    gpio_in = 16'hFA1D;
    tick(); chk("se_valid_1", 32'(evt_valid), 0);
    tick(); chk("se_valid_2", 32'(evt_valid), 0);
    tick(); chk("se_valid_3", 32'(evt_valid), 1);
    chk("se_rd_val", 32'(rd_val), 32'h0000FA1D);
    chk("se_rd_ts", 32'(rd_ts), 7);
    pop_one();
    chk("se_pop_cnt", 32'(evt_cnt), 0);
    chk("se_pop_irq", 32'(irq), 0);

    // Masking: only rising bit 0 is enabled
    rise_en = 16'h0001; fall_en = 16'h0000;
    ticks(2);
    gpio_in = 16'hFA1C; ticks(4); chk("mask_fall0", 32'(evt_cnt), 0);
    gpio_in = 16'hFA1E; ticks(4); chk("mask_rise1", 32'(evt_cnt), 0);
    gpio_in = 16'hFA1C; ticks(4); chk("mask_fall1", 32'(evt_cnt), 0);
    gpio_in = 16'hFA1D; ticks(4); chk("mask_rise0", 32'(evt_cnt), 1);
    chk("mask_rd_val", 32'(rd_val), 32'h0000FA1D);
    pop_one();

    // Multi-bit change gives a single entry
    rise_en = 16'hFFFF; fall_en = 16'hFFFF;
    gpio_in = 16'h0000; ticks(4);
    chk("multi_fall_cnt", 32'(evt_cnt), 1);
    pop_one();
    gpio_in = 16'hFFFF; ticks(6);
    chk("multi_cnt", 32'(evt_cnt), 1);
    chk("multi_rd_val", 32'(rd_val), 32'h0000FFFF);
    pop_one();

    // Overflow: five edges into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      gpio_in[0] = ~gpio_in[0];
      ticks(2);
    end
    ticks(3);
    chk("ovf_cnt", 32'(evt_cnt), 4);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_head", 32'(rd_val), 32'h0000FFFE);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);

    // Full FIFO with push and pop together
    gpio_in[0] = 1'b1;
    ticks(2);
    pop_one();
    chk("full_pp_cnt", 32'(evt_cnt), 4);
    chk("full_pp_ovf", 32'(ovf), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_val", 32'(rd_val), 32'(exp_drain[i]));
      pop_one();
    end
    chk("drain_cnt", 32'(evt_cnt), 0);

    // Timestamp wrap on the 4-bit instance: events detected at ts 15 and 0
    while (c % 16 != 13) tick();
    gpio_in[0] = 1'b0; tick();
    gpio_in[0] = 1'b1; tick();
    ticks(2);
    chk("wrap_cnt", 32'(evt_cnt4), 2);
    chk("wrap_ts15", 32'(rd_ts4), 15);
    pop_one();
    chk("wrap_ts0", 32'(rd_ts4), 0);

    // Reset with three entries queued
    gpio_in[0] = 1'b0; ticks(2);
    gpio_in[0] = 1'b1; ticks(3);
    chk("pre_rst_cnt", 32'(evt_cnt), 3);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mid_rst_cnt", 32'(evt_cnt), 0);
    chk("mid_rst_irq", 32'(irq), 0);
    chk("mid_rst_rd_val", 32'(rd_val), 0);
    chk("mid_rst_rd_ts", 32'(rd_ts), 0);
    ticks(4);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) gpio_in = 16'($urandom);
      if ($urandom_range(19) == 0) rise_en = 16'($urandom);
      if ($urandom_range(19) == 0) fall_en = 16'($urandom);
      rd_en   = ($urandom_range(3) == 0);
      ovf_clr = ($urandom_range(7) == 0);
      rst     = ($urandom_range(149) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
